// File: rtl/weight_output_serializer.sv
// Captures one 8-element complex weight vector and streams it out one {I,Q}
// element per beat over valid/ready, with back-to-back loads allowed on the last beat.
module weight_output_serializer #(
    parameter int DW    = 18,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [8*DW-1:0]      w14,
    input  logic [8*DW-1:0]      w58,
    output logic                 load_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DW-1:0]      out_data,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic                 drop,
    output logic [CNT_W-1:0]     vec_count
);

    // Handshake: a beat moves when out_valid && out_ready on a rising edge;
    // a load is taken when load && load_ready on a rising edge.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [2:0]           idx, idx_next;
    logic [16*DW-1:0]     shadow;
    logic                 xfer, last_xfer, accept;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        xfer       = (state == SEND) && out_ready;
        last_xfer  = xfer && (idx == 3'd7);
        load_ready = (state == IDLE) || last_xfer;
        accept     = load && load_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                    idx_next   = 3'd0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx == 3'd7) begin
                        idx_next   = 3'd0;
                        // A load taken on the final beat keeps the stream gapless.
                        state_next = accept ? SEND : IDLE;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            shadow    <= '0;
            drop      <= 1'b0;
            vec_count <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (accept) begin
                shadow <= {w14, w58};
            end
            drop <= load && !load_ready;
            if (last_xfer) begin
                vec_count <= vec_count + CNT_W'(1);
            end
        end
    end

    // Element 0 (w1) sits in the MSBs of the shadow register.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (idx == 3'(k)) begin
                out_data = shadow[16*DW-1-k*2*DW -: 2*DW];
            end
        end
    end

    assign out_valid = (state == SEND);
    assign out_idx   = idx;
    assign out_last  = (state == SEND) && (idx == 3'd7);

endmodule

// File: tb/tb_weight_output_serializer.sv
// Bench for weight_output_serializer: directed table, hand-written corner
// sequences, then random traffic against a queue-based beat model.
module tb_weight_output_serializer;

    localparam int DW    = 18;
    localparam int CNT_W = 16;
    localparam int VW    = 16 * DW;

    logic              clk = 1'b0;
    logic              rst, load, out_ready;
    logic [8*DW-1:0]   w14, w58;
    logic              load_ready, out_valid, out_last, drop;
    logic [2*DW-1:0]   out_data;
    logic [2:0]        out_idx;
    logic [CNT_W-1:0]  vec_count;

    int n_pass  = 0;
    int n_total = 0;

    weight_output_serializer #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .w14(w14), .w58(w58),
        .load_ready(load_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .drop(drop), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             load;
        logic             rdy;
        int               pat;
        logic             ev;
        logic [2:0]       eidx;
        logic [2*DW-1:0]  edata;
        logic             elast;
        logic             elr;
        logic             edrop;
        logic [CNT_W-1:0] evc;
    } vec_t;

    vec_t tbl[10];

    // Expected beats, each packed as {idx, data}.
    logic [2*DW+2:0]  exp_q[$];
    logic [CNT_W-1:0] m_vc;
    logic             m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [VW-1:0] pat(input int base);
        logic [VW-1:0]   v;
        logic [DW-1:0]   i, q;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            i = DW'(base + k + 1);
            q = DW'(-(base + k + 1));
            v = (v << (2*DW)) | VW'({i, q});
        end
        return v;
    endfunction

    function automatic logic [2*DW-1:0] elem(input logic [VW-1:0] v, input int k);
        logic [VW-1:0] t;
        t = v >> ((7 - k) * 2 * DW);
        return t[2*DW-1:0];
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v = (v << 32) | VW'($urandom);
        return v;
    endfunction

    task automatic apply(input logic r, input logic l, input logic rd, input logic [VW-1:0] v);
        rst       = r;
        load      = l;
        out_ready = rd;
        w14       = v[VW-1:8*DW];
        w58       = v[8*DW-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [2:0] eidx,
                           input logic [2*DW-1:0] edata, input logic chkdata,
                           input logic elast, input logic elr, input logic edrop,
                           input logic [CNT_W-1:0] evc);
        chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".idx"}, 64'(out_idx), 64'(eidx));
        if (chkdata) chk({tag, ".data"}, 64'(out_data), 64'(edata));
        chk({tag, ".last"}, 64'(out_last), 64'(elast));
        chk({tag, ".load_ready"}, 64'(load_ready), 64'(elr));
        chk({tag, ".drop"}, 64'(drop), 64'(edrop));
        chk({tag, ".vec_count"}, 64'(vec_count), 64'(evc));
    endtask

    initial begin
        logic [VW-1:0] va;
        logic          done;
        int            k;
        logic          rd, r, l;
        logic          m_valid, m_lr;
        logic [2*DW+2:0] b;
        logic [1:0]    rp [4];

        // Single vector of pattern A, with a rejected load while idx 3 is on the wire.
        va = pat(0);
        tbl[0] = '{rst:0, load:1, rdy:1, pat:0, ev:0, eidx:0, edata:0,
                   elast:0, elr:1, edrop:0, evc:0};
        for (int j = 0; j < 8; j++) begin
            tbl[j+1] = '{rst:0, load:(j == 3), rdy:1, pat:((j == 3) ? 500 : 0),
                         ev:1, eidx:3'(j), edata:elem(va, j), elast:(j == 7),
                         elr:(j == 7), edrop:(j == 4), evc:0};
        end
        tbl[9] = '{rst:0, load:0, rdy:1, pat:0, ev:0, eidx:0, edata:0,
                   elast:0, elr:1, edrop:0, evc:1};

        apply(1'b1, 1'b0, 1'b1, rnd_vec());
        tick();
        tick();
        apply(1'b0, 1'b0, 1'b1, '0);
        #2;
        chk_all("reset", 0, 0, 0, 1, 0, 1, 0, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].rst, tbl[i].load, tbl[i].rdy, pat(tbl[i].pat));
            #2;
            chk_all($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].eidx, tbl[i].edata,
                    tbl[i].ev, tbl[i].elast, tbl[i].elr, tbl[i].edrop, tbl[i].evc);
            tick();
        end

        // Backpressure with out_ready 1,0,0,1 and inputs scrambled every cycle.
        rp[0] = 1; rp[1] = 0; rp[2] = 0; rp[3] = 1;
        va = pat(20);
        apply(1'b0, 1'b1, 1'b1, va);
        #2;
        chk("bp.load_ready", 64'(load_ready), 64'd1);
        tick();
        k = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            rd = rp[cyc % 4][0];
            apply(1'b0, 1'b0, rd, rnd_vec());
            #2;
            chk_all($sformatf("bp[%0d]", cyc), 1, 3'(k), elem(va, k), 1, (k == 7),
                    rd && (k == 7), 0, 1);
            if (rd) begin
                if (k == 7) done = 1'b1;
                else k++;
            end
            tick();
        end
        if (!done) chk("bp.timeout", 64'd0, 64'd1);
        apply(1'b0, 1'b0, 1'b1, '0);
        #2;
        chk_all("bp.end", 0, 0, 0, 0, 0, 1, 0, 2);
        tick();

        // Back-to-back: vector D loaded on the final beat of vector C.
        va = pat(40);
        apply(1'b0, 1'b1, 1'b1, va);
        tick();
        for (int j = 0; j < 8; j++) begin
            if (j == 7) apply(1'b0, 1'b1, 1'b1, pat(60));
            else apply(1'b0, 1'b0, 1'b1, rnd_vec());
            #2;
            chk_all($sformatf("b2b_c[%0d]", j), 1, 3'(j), elem(va, j), 1, (j == 7),
                    (j == 7), 0, 2);
            tick();
        end
        va = pat(60);
        for (int j = 0; j < 8; j++) begin
            apply(1'b0, 1'b0, 1'b1, rnd_vec());
            #2;
            chk_all($sformatf("b2b_d[%0d]", j), 1, 3'(j), elem(va, j), 1, (j == 7),
                    (j == 7), 0, 3);
            tick();
        end
        apply(1'b0, 1'b0, 1'b1, '0);
        #2;
        chk_all("b2b.end", 0, 0, 0, 0, 0, 1, 0, 4);
        tick();

        // Reset while idx 4 is on the wire, then a fresh vector.
        va = pat(80);
        apply(1'b0, 1'b1, 1'b1, va);
        tick();
        for (int j = 0; j < 5; j++) begin
            apply((j == 4), 1'b0, 1'b1, rnd_vec());
            #2;
            chk($sformatf("mid[%0d].data", j), 64'(out_data), 64'(elem(va, j)));
            tick();
        end
        apply(1'b0, 1'b0, 1'b1, rnd_vec());
        #2;
        chk_all("mid.after_rst", 0, 0, 0, 1, 0, 1, 0, 0);
        tick();
        va = pat(100);
        apply(1'b0, 1'b1, 1'b1, va);
        tick();
        apply(1'b0, 1'b0, 1'b1, rnd_vec());
        #2;
        chk_all("mid.reload", 1, 0, elem(va, 0), 1, 0, 0, 0, 0);
        tick();

        // Random traffic against the beat-queue model.
        apply(1'b1, 1'b0, 1'b1, '0);
        tick();
        exp_q.delete();
        m_vc   = '0;
        m_drop = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            va = rnd_vec();
            apply(r, l, rd, va);
            #2;
            m_valid = (exp_q.size() > 0);
            m_lr    = (exp_q.size() == 0) || (exp_q.size() == 1 && rd);
            chk("rnd.valid", 64'(out_valid), 64'(m_valid));
            chk("rnd.load_ready", 64'(load_ready), 64'(m_lr));
            chk("rnd.drop", 64'(drop), 64'(m_drop));
            chk("rnd.vec_count", 64'(vec_count), 64'(m_vc));
            if (m_valid) begin
                chk("rnd.data", 64'(out_data), 64'(exp_q[0][2*DW-1:0]));
                chk("rnd.idx", 64'(out_idx), 64'(exp_q[0][2*DW+2:2*DW]));
                chk("rnd.last", 64'(out_last), 64'(exp_q[0][2*DW+2:2*DW] == 3'd7));
            end else begin
                chk("rnd.idle_idx", 64'(out_idx), 64'd0);
                chk("rnd.idle_last", 64'(out_last), 64'd0);
            end
            if (r) begin
                exp_q.delete();
                m_vc   = '0;
                m_drop = 1'b0;
            end else begin
                if (m_valid && rd) begin
                    b = exp_q.pop_front();
                    if (b[2*DW+2:2*DW] == 3'd7) m_vc = m_vc + 1'b1;
                end
                m_drop = l && !m_lr;
                if (l && m_lr) begin
                    for (int j = 0; j < 8; j++) exp_q.push_back({3'(j), elem(va, j)});
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
